// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin scan of four 7-segment digits sharing one
// segment bus. Each slot opens with a blanking interval to suppress ghosting.
// New readings enter through a one-deep shadow buffer and are applied only
// at the frame boundary, so a frame never shows a mix of two readings.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  dp_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    if ((BLANK_CYC < 1) || (CLK_DIV < (BLANK_CYC + 1))) begin : g_param_check
        $error("seg_scan_ctrl: illegal CLK_DIV/BLANK_CYC combination");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-low hex glyphs, bit 0 = segment a, bit 6 = segment g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // True when digit d and every more-significant digit are zero; digit 0
    // is never blanked so a zero reading still shows "0".
    function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] dig);
        logic b;
        case (dig)
            2'd3:    b = (d[15:12] == 4'h0);
            2'd2:    b = (d[15:8]  == 8'h00);
            2'd1:    b = (d[15:4]  == 12'h000);
            default: b = 1'b0;
        endcase
        return b;
    endfunction
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          shadow_full_q, shadow_full_d;
    logic          load_ready_q, load_ready_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic [3:0]    an_n_q, an_n_d;
    logic          frame_done_q, frame_done_d;

    logic          cnt_wrap_s;
    logic          frame_end_s;
    logic          accept_s;
    logic [3:0]    nib_s;

    // Slot counter and digit index; the digit-3 wrap marks the frame boundary.
    always_comb begin
        cnt_wrap_s  = (cnt_q == CNT_LAST);
        frame_end_s = cnt_wrap_s && (dig_q == 2'd3);
        if (cnt_wrap_s) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            dig_d = dig_q;
        end
    end

    // Blank/drive phase within the slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_d == CNT_BLANK) begin
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (cnt_wrap_s) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Shadow capture on handshake; shadow-to-display copy only at frame end.
    // Ready is derived from the registered full flag so it rises one cycle
    // after the boundary copy and drops right after an acceptance.
    always_comb begin
        accept_s      = load_valid && load_ready_q;
        disp_d        = disp_q;
        disp_dp_d     = disp_dp_q;
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_full_d = shadow_full_q;
        if (frame_end_s && shadow_full_q) begin
            disp_d        = shadow_q;
            disp_dp_d     = shadow_dp_q;
            shadow_full_d = 1'b0;
        end else begin
            disp_d = disp_q;
        end
        if (accept_s) begin
            shadow_d      = load_data;
            shadow_dp_d   = dp_sel;
            shadow_full_d = 1'b1;
        end else begin
            shadow_d = shadow_q;
        end
        load_ready_d = ~shadow_full_q & ~accept_s;
    end

    // Pin values for the current slot position, registered one cycle later.
    always_comb begin
        seg_n_d      = 7'h7F;
        dp_n_d       = 1'b1;
        an_n_d       = 4'hF;
        frame_done_d = frame_end_s;
        nib_s        = disp_q[{dig_q, 2'b00} +: 4];
        case (state_q)
            ST_DRIVE: begin
                an_n_d = ~(4'b0001 << dig_q);
`ifdef SEG_SCAN_LZB_EN
                if (lz_blank(disp_q, dig_q)) begin
                    seg_n_d = 7'h7F;
                end else begin
                    seg_n_d = hex_glyph(nib_s);
                end
`else
                seg_n_d = hex_glyph(nib_s);
`endif
                dp_n_d = ~disp_dp_q[dig_q];
            end
            ST_BLANK: begin
                seg_n_d = 7'h7F;
            end
            default: begin
                seg_n_d = 7'h7F;
            end
        endcase
    end

    // State, buffers and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            dig_q         <= 2'd0;
            disp_q        <= 16'h0000;
            disp_dp_q     <= 4'h0;
            shadow_q      <= 16'h0000;
            shadow_dp_q   <= 4'h0;
            shadow_full_q <= 1'b0;
            load_ready_q  <= 1'b1;
            seg_n_q       <= 7'h7F;
            dp_n_q        <= 1'b1;
            an_n_q        <= 4'hF;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            disp_q        <= disp_d;
            disp_dp_q     <= disp_dp_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_full_q <= shadow_full_d;
            load_ready_q  <= load_ready_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
// The stimulus pushes the hand-computed glyphs expected for each frame into
// a queue; the monitor pops one entry per frame and checks every pin cycle.
module tb_seg_scan_ctrl;

    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * CD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  dp_sel = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dp_sel     (dp_sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] seg;   // digit i glyph at [7*i +: 7]
        logic [3:0]  dpn;   // expected dp_n per digit
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     p = 0;          // clock edges since reset release
    bit     mon_en = 1'b0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GB = 7'h7F;

    always @(posedge clk or negedge reset) begin
        if (!reset) p <= 0;
        else        p <= p + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, p);
        end
    endtask

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn);
        frame_t f;
        f.seg = {s3, s2, s1, s0};
        f.dpn = dpn;
        exp_q.push_back(f);
    endtask

    task automatic wait_p(input int n);
        int k;
        k = 0;
        while (p != n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (p != n) begin
            checks++;
            errors++;
            $display("FAIL wait_edge: got %0d expected %0d", p, n);
        end
    endtask

    // Monitor: per-cycle pin check against slot position and current frame.
    initial begin
        frame_t     cur;
        int         q;
        int         slot;
        int         c;
        logic [3:0] exp_an;
        cur = '1;
        forever begin
            @(negedge clk);
            if (mon_en && reset && p > 0) begin
                q    = (p - 1) % FR;
                slot = q / CD;
                c    = q % CD;
                if (q == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1 (edge %0d)", p);
                        cur = '1;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                check("frame_done", {31'd0, frame_done}, {31'd0, (q == FR - 1)});
                if (c < BC) begin
                    check("blank_an", {28'd0, an_n}, 32'h0000000F);
                    check("blank_seg", {25'd0, seg_n}, 32'h0000007F);
                    check("blank_dp", {31'd0, dp_n}, 32'h00000001);
                end else begin
                    exp_an = ~(4'b0001 << slot);
                    check("drive_an", {28'd0, an_n}, {28'd0, exp_an});
                    check("drive_seg", {25'd0, seg_n}, {25'd0, cur.seg[7*slot +: 7]});
                    check("drive_dp", {31'd0, dp_n}, {31'd0, cur.dpn[slot]});
                end
            end
        end
    end

    // Stimulus: directed loads at fixed edges; expected frames pushed on issue.
    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg_n}, 32'h7F);
        check("rst_dp", {31'd0, dp_n}, 32'h1);
        check("rst_an", {28'd0, an_n}, 32'hF);
        check("rst_frame_done", {31'd0, frame_done}, 32'h0);
        check("rst_load_ready", {31'd0, load_ready}, 32'h1);

        // Idle scan: two frames of zeros.
        push_frame(G0, G0, G0, G0, 4'hF);
        push_frame(G0, G0, G0, G0, 4'hF);
        mon_en = 1'b1;
        reset  = 1'b1;

        wait_p(20);
        check("idle_ready", {31'd0, load_ready}, 32'h1);

        // Mid-frame load in slot 1 of frame 1; shown from frame 2.
        wait_p(42);
        check("pre_load_ready", {31'd0, load_ready}, 32'h1);
        load_valid = 1'b1;
        load_data  = 16'h1E08;
        dp_sel     = 4'b0100;
        push_frame(G1, GE, G0, G8, 4'b1011);
        wait_p(43);
        check("ready_low_after_accept", {31'd0, load_ready}, 32'h0);

        // Back-to-back: hold 2222 while 1E08 is pending; shown in frame 3.
        load_data = 16'h2222;
        dp_sel    = 4'b0000;
        push_frame(G2, G2, G2, G2, 4'hF);
        wait_p(64);
        check("ready_low_at_boundary", {31'd0, load_ready}, 32'h0);
        wait_p(65);
        check("ready_after_frame_done", {31'd0, load_ready}, 32'h1);
        wait_p(66);
        check("ready_low_second_accept", {31'd0, load_ready}, 32'h0);
        load_valid = 1'b0;

        // 0007 with dp on digit 1, shown in frame 4.
        wait_p(96);
        check("ready_low_boundary2", {31'd0, load_ready}, 32'h0);
        wait_p(97);
        check("ready_high2", {31'd0, load_ready}, 32'h1);
        load_valid = 1'b1;
        load_data  = 16'h0007;
        dp_sel     = 4'b0010;
`ifdef SEG_SCAN_LZB_EN
        push_frame(GB, GB, GB, G7, 4'b1101);
`else
        push_frame(G0, G0, G0, G7, 4'b1101);
`endif
        wait_p(98);
        load_valid = 1'b0;

        // 0000, shown in frame 5; digit 0 keeps its glyph.
        wait_p(130);
        check("ready_high3", {31'd0, load_ready}, 32'h1);
        load_valid = 1'b1;
        load_data  = 16'h0000;
        dp_sel     = 4'b0000;
`ifdef SEG_SCAN_LZB_EN
        push_frame(GB, GB, GB, G0, 4'hF);
`else
        push_frame(G0, G0, G0, G0, 4'hF);
`endif
        wait_p(131);
        load_valid = 1'b0;

        // Pending load of 8888, then reset mid-DRIVE of slot 0.
        wait_p(161);
        load_valid = 1'b1;
        load_data  = 16'h8888;
        dp_sel     = 4'hF;
        wait_p(162);
        load_valid = 1'b0;
        check("pending_ready_low", {31'd0, load_ready}, 32'h0);
        wait_p(165);
        check("mid_drive_an", {28'd0, an_n}, 32'hE);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_an", {28'd0, an_n}, 32'hF);
        check("async_rst_seg", {25'd0, seg_n}, 32'h7F);
        check("async_rst_dp", {31'd0, dp_n}, 32'h1);
        check("async_rst_ready", {31'd0, load_ready}, 32'h1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // After release the pending value must never appear.
        push_frame(G0, G0, G0, G0, 4'hF);
        push_frame(G0, G0, G0, G0, 4'hF);
        repeat (3) @(negedge clk);
        check("held_rst_an", {28'd0, an_n}, 32'hF);
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_p(64);
        #1;
        mon_en = 1'b0;
        check("final_ready", {31'd0, load_ready}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler for the voltmeter's shared 7-segment bus. It owns one 7-bit segment bus plus decimal point, and shares it among four digit anodes in round-robin slots. A blanking interval at the start of each slot suppresses ghosting. A double-buffered load handshake applies each new reading atomically at a frame boundary. The block sits between the measurement/BCD conversion logic and the board display pins.

## Interface
- CLK_DIV, 50000: clk cycles per digit slot; legal range ≥ BLANK_CYC+1.
- BLANK_CYC, 500: blank cycles at start of each slot; legal range ≥ 1. Illegal combinations raise `$error` at elaboration.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- load_valid  in  1  producer offers load_data/dp_sel
- load_ready  out  1  shadow register empty; transfer occurs when load_valid & load_ready
- load_data  in  16  four hex/BCD nibbles; [3:0]=digit0 (rightmost) … [15:12]=digit3
- dp_sel  in  4  decimal-point enable per digit, captured with load_data
- seg_n  out  7  segments, active-low; [0]=a … [6]=g
- dp_n  out  1  decimal point, active-low
- an_n  out  4  digit anodes, active-low; [i]=digit i
- frame_done  out  1  one-cycle pulse on the last cycle of the digit-3 slot

## Operation
- **Registers**
  - Slot counter `cnt`: 0..CLK_DIV-1.
  - Digit index `dig`: 2 bits.
  - Display register: 16 bits data + 4 bits dp.
  - Shadow register, plus a `shadow_full` flag.
- **States**
  - BLANK: cnt < BLANK_CYC.
  - DRIVE: BLANK_CYC ≤ cnt < CLK_DIV.
  - BLANK→DRIVE when cnt reaches BLANK_CYC.
  - DRIVE→BLANK at cnt = CLK_DIV-1, when cnt wraps to 0 and dig increments.
  - dig wraps 3→0. This wrap is the frame boundary.
- **BLANK outputs:** an_n=4'hF, seg_n=7'h7F, dp_n=1.
- **DRIVE outputs:**
  - an_n has only bit dig low.
  - seg_n = hex glyph of the display nibble dig.
  - dp_n = ~dp[dig].
- **Glyphs:** standard hex, with b and d lowercase.
  - '0'=7'b1000000, '1'=7'b1111001, '7'=7'b1111000, '8'=7'b0000000, 'E'=7'b0000110.
- **Load handshake**
  - On handshake, capture into the shadow and set shadow_full.
  - load_ready = ~shadow_full, registered; it is low from the cycle after acceptance.
  - At the frame boundary, if shadow_full, copy shadow → display and clear shadow_full. load_ready rises the following cycle.
  - A handshake accepted in the boundary cycle itself stays in the shadow until the next frame boundary.
  - load_valid while load_ready=0 is ignored; the producer holds it.
- The display register never changes mid-frame, so there is no tearing.

## Timing
- **Reset values**
  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_done=0, load_ready=1.
  - Internal: display=0, dp=0, shadow empty, cnt=0, dig=0, state BLANK.
- Reset asserted at any time forces all of the above immediately (asynchronously), discarding any pending shadow.
- Slot 0 cycle 0 is the first clk edge after reset deassertion.
- **Output registration**
  - All outputs are registered.
  - Pins reflect the slot position with exactly one cycle of latency, uniformly, so the blank and drive lengths at the pins are unaffected.
- **Cycle counts**
  - Per slot at the pins: BLANK_CYC blank cycles, then CLK_DIV-BLANK_CYC driven cycles.
  - Frame = 4·CLK_DIV cycles; frame_done has period 4·CLK_DIV.
  - Load latency to the pins: from handshake to first driven digit ≤ 4·CLK_DIV + BLANK_CYC + 1 cycles.
- There is never more than one anode low, and never an anode low during a blank cycle, including across slot and frame wrap.

## Configuration
- **SEG_SCAN_LZB_EN** defined: leading-zero blanking.
  - During DRIVE, digit i (i = 3, 2, 1) outputs seg_n=7'h7F when nibble i and all more-significant nibbles are 0.
  - The anode still asserts, and dp_n still follows dp_sel.
  - Digit 0 is never blanked.
- Undefined: every digit always shows its glyph.

## Test plan
All scenarios use CLK_DIV=8, BLANK_CYC=2.

1. **Reset and idle scan.** Release reset.
   - Pins: 2 cycles 7F/1/F, then 6 cycles an_n=4'hE with seg_n=7'b1000000.
   - Then an_n=D, B, 7 in order, each slot preceded by 2 blank cycles.
   - frame_done every 32 cycles; load_ready=1.
2. **Mid-frame load.** Load 16'h1E08 with dp_sel=4'b0100 in slot 1.
   - load_ready goes low the next cycle; the remainder of the frame still shows 0000.
   - Next frame shows digit0=7'b0000000, digit1=7'b1000000, digit2=7'b0000110 with dp_n=0, digit3=7'b1111001.
   - load_ready=1 the cycle after frame_done.
3. **Back-to-back load.** Hold load_valid with 16'h2222 while a load is pending.
   - Not accepted until load_ready returns.
   - Displayed one frame after 1E08.
4. **Leading-zero blanking.** Load 16'h0007.
   - With SEG_SCAN_LZB_EN: digits 3–1 show seg_n=7'h7F, digit0 shows 7'b1111000.
   - Without it: digits 3–1 show 7'b1000000.
   - Load 16'h0000 with the macro defined: digit0 still shows 7'b1000000.
5. **Reset mid-operation.** Assert reset mid-DRIVE while a load is pending.
   - Pins go blank with no clock edge; load_ready=1.
   - After release, all digits show 0; the pending value never appears.
